// File: rtl/inst_loader.sv
// Byte-stream instruction loader: assembles big-endian 16-bit words from a
// byte stream, writes them to instruction memory and releases the CPU on HALT.
module inst_loader #(
    parameter int          ADDR_W  = 8,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   WC_ONE   = 1;

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                addr_last;

    assign addr_last = &addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HI;
                    addr_d  = '0;
                    wc_d    = '0;
                end
            end
            S_HI: begin
                if (in_valid) begin
                    hi_d    = in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (in_valid) begin
                    wdata_d = {hi_q, in_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wc_d = wc_q + WC_ONE;
                // The last address is held rather than wrapped; ERR or DONE follows.
                if (!addr_last) begin
                    addr_d = addr_q + ADDR_ONE;
                end
                if (wdata_q[15:12] == HALT_OP) begin
                    state_d = S_DONE;
                end else if (addr_last) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_HI) || (state_q == S_LO);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_run    = (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign word_count = wc_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: a default-width instance and a 2-bit
// address instance share one stimulus path selected by sel.
module tb_inst_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sel;

    always #5 clk = ~clk;

    logic        o8_ready, o8_we, o8_run, o8_done, o8_err;
    logic [7:0]  o8_addr;
    logic [15:0] o8_wdata;
    logic [8:0]  o8_wc;
    logic        o2_ready, o2_we, o2_run, o2_done, o2_err;
    logic [1:0]  o2_addr;
    logic [15:0] o2_wdata;
    logic [2:0]  o2_wc;

    inst_loader #(.ADDR_W(8), .HALT_OP(4'b1111)) u_dut8 (
        .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_data(in_data), .in_ready(o8_ready), .mem_we(o8_we), .mem_addr(o8_addr),
        .mem_wdata(o8_wdata), .cpu_run(o8_run), .done(o8_done), .err(o8_err),
        .word_count(o8_wc)
    );

    inst_loader #(.ADDR_W(2), .HALT_OP(4'b1111)) u_dut2 (
        .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel),
        .in_data(in_data), .in_ready(o2_ready), .mem_we(o2_we), .mem_addr(o2_addr),
        .mem_wdata(o2_wdata), .cpu_run(o2_run), .done(o2_done), .err(o2_err),
        .word_count(o2_wc)
    );

    logic        c_ready, c_we, c_run, c_done, c_err;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata;
    logic [8:0]  c_wc;

    assign c_ready = sel ? o2_ready : o8_ready;
    assign c_we    = sel ? o2_we    : o8_we;
    assign c_run   = sel ? o2_run   : o8_run;
    assign c_done  = sel ? o2_done  : o8_done;
    assign c_err   = sel ? o2_err   : o8_err;
    assign c_addr  = sel ? {6'b0, o2_addr} : o8_addr;
    assign c_wdata = sel ? o2_wdata : o8_wdata;
    assign c_wc    = sel ? {6'b0, o2_wc} : o8_wc;

    logic [23:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  acc;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            acc      = c_ready;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept actual=timeout required=accepted byte=%0h", b);
        end
    endtask

    // Expected writes come from the program alone: words in order from address 0,
    // stopping after the first HALT word or once the memory is full.
    task automatic run_program(input logic [15:0] prog[$], input int gap, input bit lo_pulse);
        int cap;
        int n;
        int k;
        int g;
        bit halted;
        cap = sel ? 4 : 256;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_flags", {c_ready, c_we, c_run, c_done, c_err}, 5'b10000);
        chk("restart_wc", c_wc, 0);
        chk("restart_addr", c_addr, 0);
        n = 0;
        halted = 1'b0;
        foreach (prog[i]) begin
            if (halted || n == cap) break;
            exp_q.push_back({8'(n), prog[i]});
            n++;
            if (prog[i][15:12] == 4'hF) halted = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            send_byte(prog[i][15:8], g);
            if (lo_pulse && i == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b1;
                chk("lo_ready", c_ready, 1);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(prog[i][7:0], g);
        end
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!(c_done || c_err) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("end_flags", {c_done, c_err, c_run}, halted ? 3'b101 : 3'b010);
        chk("end_wc", c_wc, n);
        chk("end_ready", c_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk("no_accept", c_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] prog[$];
        logic [15:0] w;
        int len;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 1'b0;
        #1;
        chk("reset_outputs", {c_ready, c_we, c_addr, c_wdata, c_run, c_done, c_err, c_wc}, 0);

        fork
            forever begin
                logic [23:0] e;
                @(negedge clk);
                if (c_we === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%0h:%0h required=none", c_addr, c_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", {c_addr, c_wdata}, e);
                        chk("ready_in_write", c_ready, 0);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        rst = 1'b0;

        prog = '{16'h0021, 16'hF000};
        run_program(prog, 0, 1'b0);
        run_program(prog, 1, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hF0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midword_reset_outputs", {c_ready, c_we, c_addr, c_wdata, c_run, c_done, c_err, c_wc}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        prog = '{16'hF000};
        run_program(prog, 0, 1'b0);

        prog = '{16'h1111, 16'h2222, 16'hF333};
        run_program(prog, -1, 1'b1);

        sel  = 1'b1;
        prog = '{16'h1234, 16'h0000, 16'h5555, 16'h0AAA};
        run_program(prog, 0, 1'b0);

        for (int s = 0; s < 20; s++) begin
            sel = 1'($urandom_range(0, 1));
            prog.delete();
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom);
                if (sel) begin
                    w[15:12] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'(i);
                end else if (w[15:12] == 4'hF) begin
                    w[15:12] = 4'h7;
                end
                prog.push_back(w);
            end
            if (!sel || len < 4) begin
                w = 16'($urandom);
                w[15:12] = 4'hF;
                prog.push_back(w);
            end
            run_program(prog, -1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
